// File: rtl/drum_mul_arbiter.sv
// drum_mul_arbiter: round-robin arbiter that shares one 16x16 multiplier among
// NREQ requesters. The multiplier gives either the DRUM4 approximate product
// (k=4 dynamic-range truncation) or the exact product. The datapath is a
// two-stage pipeline: S1 holds the operands, S2 holds the response. Responses
// are tagged with the requester index and can be back-pressured.
module drum_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [16*NREQ-1:0] req_a,
    input  logic [16*NREQ-1:0] req_b,
    output logic [NREQ-1:0]    req_ready,
    input  logic               approx_en,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IW-1:0]      rsp_id,
    output logic [31:0]        rsp_r,
    output logic               busy,
    output logic [15:0]        op_count
);

    // Encodes one operand for DRUM4 and returns {shift[3:0], mantissa[3:0]}.
    // The mantissa keeps the leading one and the next two bits. Its lowest bit
    // is forced to 1, which makes the truncation error unbiased. A zero operand
    // encodes to mantissa 0, so the product becomes 0 with no special case.
    function automatic logic [7:0] drum_enc(input logic [15:0] x);
        logic [3:0] k;
        logic [7:0] r;
        k = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (x[i]) k = 4'(i);
        end
        if (k <= 4'd3) r = {4'd0, x[3:0]};
        else           r = {k - 4'd3, 1'b1, x[k - 4'd1], x[k - 4'd2], 1'b1};
        return r;
    endfunction

    // S1 operand stage
    logic [15:0]   a1;
    logic [15:0]   b1;
    logic [IW-1:0] id1;
    logic          mode1;
    logic          v1;

    // Arbitration state
    logic [IW-1:0] rr_ptr;
    logic [NREQ-1:0] grant;
    logic [IW-1:0] gidx;
    logic          found;
    int            idx;

    // Pipeline control
    logic adv1;
    logic adv2;
    logic take;
    logic rsp_fire;

    // Multiplier datapath
    logic [7:0]  enc_a;
    logic [7:0]  enc_b;
    logic [7:0]  mant_prod;
    logic [4:0]  shamt;
    logic [31:0] prod_exact;
    logic [31:0] prod_drum;
    logic [31:0] prod;

    assign adv2     = v1 & (~rsp_valid | rsp_ready);
    assign adv1     = ~v1 | adv2;
    assign rsp_fire = rsp_valid & rsp_ready;
    assign busy     = v1 | rsp_valid;

    // Pick the first valid requester, searching upward from rr_ptr and wrapping around.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_ptr) + i) % NREQ;
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gidx       = IW'(idx);
            end
        end
    end

    // A grant is only offered when S1 can accept it and the block is out of reset.
    assign take      = found & adv1 & rst_n;
    assign req_ready = take ? grant : '0;

    // Multiply the S1 operands in the mode that was captured at grant time.
    always_comb begin
        enc_a      = drum_enc(a1);
        enc_b      = drum_enc(b1);
        mant_prod  = {4'd0, enc_a[3:0]} * {4'd0, enc_b[3:0]};
        shamt      = {1'b0, enc_a[7:4]} + {1'b0, enc_b[7:4]};
        prod_drum  = {24'd0, mant_prod} << shamt;
        prod_exact = {16'd0, a1} * {16'd0, b1};
        prod       = mode1 ? prod_drum : prod_exact;
    end

    // S1: capture the granted operands and advance the round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1     <= '0;
            b1     <= '0;
            id1    <= '0;
            mode1  <= 1'b0;
            v1     <= 1'b0;
            rr_ptr <= '0;
        end else if (take) begin
            a1     <= req_a[16*gidx +: 16];
            b1     <= req_b[16*gidx +: 16];
            id1    <= gidx;
            mode1  <= approx_en;
            v1     <= 1'b1;
            rr_ptr <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
        end else if (adv2) begin
            v1 <= 1'b0;
        end
    end

    // S2: load a new product when S1 moves forward; otherwise hold until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_r     <= '0;
            rsp_id    <= '0;
            rsp_valid <= 1'b0;
        end else if (adv2) begin
            rsp_r     <= prod;
            rsp_id    <= id1;
            rsp_valid <= 1'b1;
        end else if (rsp_fire) begin
            rsp_valid <= 1'b0;
        end
    end

    // Count the responses the consumer has taken. The counter wraps freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (rsp_fire) begin
            op_count <= op_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_drum_mul_arbiter.sv
// Scoreboard bench for drum_mul_arbiter. Expected products are hand-computed
// constants. They are queued when a request handshake is observed, and a
// separate monitor pops and compares each response the DUT delivers.
`timescale 1ns/1ps
module tb_drum_mul_arbiter;

    localparam int NREQ = 4;
    localparam int IW   = 2;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [16*NREQ-1:0] req_a;
    logic [16*NREQ-1:0] req_b;
    logic [NREQ-1:0]    req_ready;
    logic               approx_en;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IW-1:0]      rsp_id;
    logic [31:0]        rsp_r;
    logic               busy;
    logic [15:0]        op_count;

    drum_mul_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .approx_en (approx_en),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_r     (rsp_r),
        .busy      (busy),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    logic [31:0] exp_cur [NREQ];
    logic [33:0] sb_q [$];
    int          grant_log [$];
    int          hs_count = 0;
    logic [15:0] n_ops = 16'd0;

    logic        held_v  = 1'b0;
    logic [31:0] held_r  = '0;
    logic [IW-1:0] held_id = '0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endfunction

    // Handshake observer and response monitor, both sampling mid-cycle.
    always @(negedge clk) begin
        logic [33:0] e;
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            chk("ready_legal", {31'd0, ((req_ready & ~req_valid) == '0) && $onehot0(req_ready)}, 32'd1);
            if (held_v) begin
                chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
                chk("hold_r", rsp_r, held_r);
                chk("hold_id", {30'd0, rsp_id}, {30'd0, held_id});
            end
            held_v  = rsp_valid && !rsp_ready;
            held_r  = rsp_r;
            held_id = rsp_id;
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected", rsp_r, 32'hDEAD_BEEF);
                end else begin
                    e = sb_q.pop_front();
                    chk("rsp_id", {30'd0, rsp_id}, {30'd0, e[33:32]});
                    chk("rsp_r", rsp_r, e[31:0]);
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb_q.push_back({IW'(i), exp_cur[i]});
                    grant_log.push_back(i);
                    hs_count++;
                end
            end
        end
    end

    // Issue one request on an idle pipeline and check its latency and the counter.
    task automatic send1(input int id, input logic [15:0] a, input logic [15:0] b,
                         input logic mode, input logic [31:0] exp, input logic flip);
        logic got;
        got = 1'b0;
        req_a[16*id +: 16] = a;
        req_b[16*id +: 16] = b;
        approx_en          = mode;
        exp_cur[id]        = exp;
        req_valid[id]      = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                got = 1'b1;
                break;
            end
        end
        chk("hs_seen", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        if (flip) approx_en = ~mode;
        @(negedge clk);
        chk("lat_s1", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("lat_s2", {31'd0, rsp_valid}, 32'd1);
        @(posedge clk); #1;
        if (got) n_ops = n_ops + 16'd1;
        chk("op_count", {16'd0, op_count}, {16'd0, n_ops});
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain", {31'd0, done}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic reached;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        approx_en = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) exp_cur[i] = '0;

        // Reset state
        repeat (2) @(posedge clk); #1;
        req_valid = '1;
        @(negedge clk);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_op_count", {16'd0, op_count}, 32'd0);
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_rsp_r", rsp_r, 32'd0);
        chk("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
        req_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single request, approximation, in-flight mode toggle, boundaries
        send1(0, 16'd3,      16'd5,      1'b1, 32'd15,          1'b0);
        send1(1, 16'd1000,   16'd1000,   1'b1, 32'd921600,      1'b0);
        send1(1, 16'd1000,   16'd1000,   1'b0, 32'd1000000,     1'b0);
        send1(2, 16'd1000,   16'd1000,   1'b1, 32'd921600,      1'b1);
        send1(2, 16'd1000,   16'd1000,   1'b0, 32'd1000000,     1'b1);
        send1(2, 16'd181,    16'd20,     1'b1, 32'd3872,        1'b0);
        send1(3, 16'd0,      16'hFFFF,   1'b1, 32'd0,           1'b0);
        send1(0, 16'hFFFF,   16'hFFFF,   1'b1, 32'hE100_0000,   1'b0);
        send1(1, 16'hFFFF,   16'hFFFF,   1'b0, 32'hFFFE_0001,   1'b0);

        // Back-pressure: requesters 1 and 2 valid while rsp_ready is low
        hs_count  = 0;
        rsp_ready = 1'b0;
        approx_en = 1'b0;
        req_a[16 +: 16] = 16'd1000; req_b[16 +: 16] = 16'd3; exp_cur[1] = 32'd3000;
        req_a[32 +: 16] = 16'd7;    req_b[32 +: 16] = 16'd9; exp_cur[2] = 32'd63;
        req_valid = 4'b0110;
        repeat (5) @(posedge clk); #1;
        @(negedge clk);
        chk("bp_accepted", 32'(hs_count), 32'd2);
        chk("bp_ready_low", {28'd0, req_ready}, 32'd0);
        chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req_valid = '0;
        @(negedge clk);
        chk("bp_rsp1", {31'd0, rsp_valid}, 32'd1);
        @(negedge clk);
        chk("bp_rsp2", {31'd0, rsp_valid}, 32'd1);
        @(negedge clk);
        chk("bp_after", {31'd0, rsp_valid}, 32'd0);
        chk("bp_sb_empty", 32'(sb_q.size()), 32'd0);
        chk("bp_no_extra", 32'(hs_count), 32'd2);
        @(posedge clk); #1;
        n_ops = n_ops + 16'd2;
        chk("bp_op_count", {16'd0, op_count}, {16'd0, n_ops});

        // Reset with S1 and S2 both full
        rsp_ready = 1'b0;
        req_a[0  +: 16] = 16'd2; req_b[0  +: 16] = 16'd2; exp_cur[0] = 32'd4;
        req_a[48 +: 16] = 16'd3; req_b[48 +: 16] = 16'd3; exp_cur[3] = 32'd9;
        req_valid = 4'b1001;
        repeat (3) @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        chk("pre_rst_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_op_count", {16'd0, op_count}, 32'd0);
        chk("mid_rst_req_ready", {28'd0, req_ready}, 32'd0);
        sb_q.delete();
        grant_log.delete();
        n_ops = 16'd0;

        // Round robin after reset: all four requesters valid
        for (int i = 0; i < NREQ; i++) begin
            req_a[16*i +: 16] = 16'(i + 1);
            req_b[16*i +: 16] = 16'd10;
            exp_cur[i] = 32'((i + 1) * 10);
        end
        approx_en = 1'b0;
        req_valid = '1;
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c >= 3) chk("rr_rsp_per_cycle", {31'd0, rsp_valid}, 32'd1);
            @(posedge clk); #1;
            if (c == 8) req_valid = '0;
        end
        @(negedge clk);
        chk("rr_tail", {31'd0, rsp_valid}, 32'd0);
        chk("rr_grants", 32'(grant_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
            chk("rr_order", 32'(grant_log[i]), 32'(i % NREQ));
        end
        @(posedge clk); #1;
        chk("rr_op_count", {16'd0, op_count}, 32'd8);

        // Stream until op_count reaches 0xFFFF, then check the wrap
        req_valid = '1;
        reached = 1'b0;
        for (int t = 0; t < 70000; t++) begin
            @(negedge clk);
            if (op_count == 16'hFFFF) begin
                reached = 1'b1;
                break;
            end
        end
        chk("wrap_reached", {31'd0, reached}, 32'd1);
        chk("wrap_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        @(posedge clk); #1;
        chk("wrap_zero", {16'd0, op_count}, 32'd0);
        req_valid = '0;
        drain();
        chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
